// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared types and constants for the load/store unit:
//   lsu_state_e  - sequencer states (IDLE/REQ/WAIT/DONE)
//   MASK_*       - func3 access size/sign encodings
//   TIMEOUT_W    - width of the request/response timeout counter
//   lane_of()    - byte lane a load result is taken from, given size and
//                  the low address bits (misaligned bits are truncated)
// ---------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] MASK_B  = 3'b000;
    localparam logic [2:0] MASK_H  = 3'b001;
    localparam logic [2:0] MASK_W  = 3'b010;
    localparam logic [2:0] MASK_BU = 3'b100;
    localparam logic [2:0] MASK_HU = 3'b101;

    localparam int TIMEOUT_W = 8;

    // size: func3[1:0] (00 byte, 01 half, 10 word)
    function automatic logic [1:0] lane_of(input logic [1:0] size, input logic [1:0] a);
        logic [1:0] lane;
        case (size)
            2'b00:   lane = a;
            2'b01:   lane = {a[1], 1'b0};
            default: lane = 2'b00;
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Purely combinational lane logic for the load/store unit.
// Ports:
//   is_store   in  1  : access is a store (selects legality rules)
//   mask       in  3  : func3 size/sign
//   addr_lo    in  2  : addr[1:0]
//   wdata      in  32 : raw store data (rs2)
//   mem_rdata  in  32 : raw word read from memory
//   be         out 4  : byte enables
//   wdata_lane out 32 : store data replicated across lanes
//   ld_data    out 32 : load result shifted down and sign/zero extended
//   misalign   out 1  : half with addr[0]=1 or word with addr[1:0]!=0
//   illegal    out 1  : func3 not valid for this access type
// ---------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  mask,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] ld_data,
    output logic        misalign,
    output logic        illegal
);

    logic [1:0]  lane;
    logic [31:0] shifted;

    always_comb begin
        be         = 4'b0000;
        wdata_lane = 32'h0;
        ld_data    = 32'h0;
        misalign   = 1'b0;
        lane       = lane_of(mask[1:0], addr_lo);
        shifted    = mem_rdata >> {lane, 3'b000};

        // Stores only have signed-size encodings; loads reject 011/110/111.
        if (is_store)
            illegal = mask[2] | (mask[1:0] == 2'b11);
        else
            illegal = (mask[1:0] == 2'b11) | (mask[2:1] == 2'b11);

        case (mask[1:0])
            2'b00: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                ld_data    = mask[2] ? {24'h0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                // addr[0] is dropped here; trapping on it is the controller's call
                be         = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_lane = {2{wdata[15:0]}};
                ld_data    = mask[2] ? {16'h0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
                misalign   = addr_lo[0];
            end
            2'b10: begin
                be         = 4'b1111;
                wdata_lane = wdata;
                ld_data    = shifted;
                misalign   = |addr_lo;
            end
            default: begin
                be         = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/lsu_controller.sv
// ---------------------------------------------------------------------------
// lsu_controller
// Multi-cycle load/store sequencer: accepts one decoded load or store, issues
// a single handshaked memory transaction, stalls the core until it completes
// or times out, and returns the extended load data.
// Parameters:
//   TIMEOUT_CYC (2..255) : max cycles spent in REQ+WAIT before abort
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   rd_en, wr_en         : load / store request (store wins if both)
//   mask, addr, wdata    : func3, byte address, store data
//   stall                : hold the pipeline
//   rdata, ld_valid, err : load result, result-valid pulse, abort pulse
//   mem_req/we/addr/be/wdata, mem_gnt, mem_rvalid, mem_rdata : memory port
// Build option:
//   LSU_MISALIGN_TRAP_EN : when defined, misaligned half/word accesses abort
//                          with err instead of truncating the low address bits
// ---------------------------------------------------------------------------
module lsu_controller
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [2:0]  mask,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        ld_valid,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit MISALIGN_TRAP = 1'b1;
`else
    localparam bit MISALIGN_TRAP = 1'b0;
`endif

    // Last counter value before abort: REQ+WAIT last TIMEOUT_CYC cycles.
    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);

    lsu_state_e            state_q, state_d;
    logic                  is_store_q, is_store_d;
    logic [2:0]            mask_q, mask_d;
    logic [1:0]            addr_lo_q, addr_lo_d;
    logic                  err_q, err_d;
    logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [31:0]           mem_addr_q, mem_addr_d;
    logic [3:0]            mem_be_q, mem_be_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;

    // The aligner sees live inputs while accepting and the captured access
    // afterwards, so one instance serves both store setup and load extension.
    logic        al_is_store;
    logic [2:0]  al_mask;
    logic [1:0]  al_addr_lo;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_ld_data;
    logic        al_misalign;
    logic        al_illegal;
    logic        in_idle;
    logic        abort_now;

    assign in_idle     = (state_q == IDLE);
    assign al_is_store = in_idle ? wr_en      : is_store_q;
    assign al_mask     = in_idle ? mask       : mask_q;
    assign al_addr_lo  = in_idle ? addr[1:0]  : addr_lo_q;

    lsu_align u_align (
        .is_store   (al_is_store),
        .mask       (al_mask),
        .addr_lo    (al_addr_lo),
        .wdata      (wdata),
        .mem_rdata  (mem_rdata),
        .be         (al_be),
        .wdata_lane (al_wdata),
        .ld_data    (al_ld_data),
        .misalign   (al_misalign),
        .illegal    (al_illegal)
    );

    assign abort_now = al_illegal | (al_misalign & MISALIGN_TRAP);

    always_comb begin
        state_d     = state_q;
        is_store_d  = is_store_q;
        mask_d      = mask_q;
        addr_lo_d   = addr_lo_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (rd_en | wr_en) begin
                    is_store_d = wr_en;
                    mask_d     = mask;
                    addr_lo_d  = addr[1:0];
                    if (abort_now) begin
                        // No memory traffic; report the abort straight away.
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                        state_d = DONE;
                    end else begin
                        err_d       = 1'b0;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = wr_en;
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_be_d    = al_be;
                        mem_wdata_d = al_wdata;
                        state_d     = REQ;
                    end
                end
            end
            REQ, WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if ((state_q == REQ) && mem_gnt) begin
                    mem_req_d = 1'b0;
                    if (mem_rvalid) begin
                        if (!is_store_q)
                            rdata_d = al_ld_data;
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                    end
                end else if ((state_q == WAIT) && mem_rvalid) begin
                    if (!is_store_q)
                        rdata_d = al_ld_data;
                    state_d = DONE;
                end else if (cnt_q == TO_LAST) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    rdata_d   = 32'h0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            is_store_q  <= 1'b0;
            mask_q      <= 3'b000;
            addr_lo_q   <= 2'b00;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            rdata_q     <= 32'h0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            is_store_q  <= is_store_d;
            mask_q      <= mask_d;
            addr_lo_q   <= addr_lo_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Stall is raised in the accept cycle itself; gating with rst_n keeps it
    // low while reset is held even if decode still presents a request.
    assign stall = rst_n & ((in_idle & (rd_en | wr_en)) |
                            (state_q == REQ) | (state_q == WAIT));

    assign ld_valid  = (state_q == DONE) & ~is_store_q & ~err_q;
    assign err       = (state_q == DONE) & err_q;
    assign rdata     = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule
